agex_stage: RTL and testbench
=============================

// Module: agex_stage
// PURPOSE
//  Execute/address-generation stage, directly downstream of decode. Consumes the decode latch fields,
//  computes ALU results, load/store addresses, branch/jump outcomes and redirects fetch on a taken control transfer.
//  MUL runs on an iterative shift-add multiplier FSM, which stalls decode.
//  The registered AGEX latch feeds the memory stage.
// PARAMETERS
//  DBITS     32  datapath width
//  MUL_STEP  4   multiplier bits retired per cycle; must divide DBITS; N_MUL = DBITS/MUL_STEP
// PORTS
//  clk               in   1          clock; one clock; reset is asynchronous and active-low
//  reset_n           in   1          asynchronous active-low reset
//  de_valid          in   1          decode latch holds a real instruction
//  de_op             in   IOPBITS    internal opcode enumerator (ADD_I..CSRW_I, INVALID_I)
//  de_pc, de_pcplus  in   DBITS      instruction PC, PC+4
//  de_rs1_val/rs2_val in  DBITS      register operands
//  de_imm            in   DBITS      sign-extended immediate
//  de_wr_reg, de_rd  in   1, 5       register writeback enable and destination
//  de_inst_count     in   DBITS      instruction sequence tag
//  br_mispred_AGEX   out  1          redirect fetch this cycle (combinational)
//  br_target_AGEX    out  DBITS      redirect PC, valid when br_mispred_AGEX=1
//  mul_stall_AGEX    out  1          decode must insert a bubble and hold fetch this cycle (combinational)
//  agex_valid, agex_op, agex_pc, agex_result, agex_st_data, agex_wr_reg, agex_rd, agex_inst_count
//                    out  registered AGEX latch to memory stage
// BEHAVIOUR
//  - Reset (async, reset_n=0): FSM=IDLE, count=0, every latch output 0, mispred=0, stall=0.
//  - Single-cycle ops: result is latched at the next posedge (latency 1).
//  - Arithmetic: ADD/ADDI/SUB wrap mod 2^32. SLT/SLTI are signed; SLTU/SLTIU are unsigned; result is 0/1.
//  - Shifts use operand[4:0]. SRA/SRAI are arithmetic.
//  - LUI result = imm. AUIPC result = pc + imm.
//  - LW/SW result = rs1 + imm (address); agex_st_data = rs2_val.
//  - Branches: target = pc + imm. If taken: mispred=1 and target is driven. If not taken: no redirect.
//  - JAL: result = pcplus, target = pc + imm, always redirect.
//  - JALR: result = pcplus, target = (rs1 + imm) & ~1, always redirect.
//  - de_valid=0 suppresses mispred and latches a bubble (agex_valid=0, agex_wr_reg=0).
//  - INVALID_I: latched with wr_reg forced to 0, no redirect.
//  - MUL FSM (result = low DBITS of rs1*rs2):
//      IDLE: valid MUL -> capture all de_* fields, acc=0, count=0, stall=1, latch gets bubble -> BUSY.
//      BUSY: each cycle acc += mcand*mplier[MUL_STEP-1:0]; mcand <<= MUL_STEP; mplier >>= MUL_STEP; count++.
//            stall=1 while count < N_MUL-1.
//            At count == N_MUL-1: stall=0, final sum latched with captured fields, agex_valid=1 -> IDLE.
//      Stall is high for exactly N_MUL cycles (accept + N_MUL-1 busy). Result appears N_MUL+1 edges after accept.
//  - In BUSY, inputs are bubbles by contract.
//      A valid input in BUSY is a protocol violation: it is dropped, and a simulation assertion fires.
//  - Mispred and stall are never high together (a branch is only consumed in IDLE).
//  - Reset mid-MUL: state is discarded immediately; no result is ever latched.
// TESTING
//  1 ADD rs1=0x7FFFFFFF rs2=1 -> agex_result=0x80000000, valid=1 next edge, mispred=0.
//  2 BEQ pc=0x100 imm=0x20 rs1=rs2=5 -> mispred=1, target=0x120 same cycle; latched wr_reg=0.
//    With rs2=6 -> mispred=0.
//  3 MUL 7*6 (MUL_STEP=4) -> stall high 8 cycles; agex_result=42 latched on the 9th edge after accept.
//    0xFFFFFFFF*2 -> 0xFFFFFFFE.
//  4 JALR rs1=0x203 imm=0 pcplus=0x44 -> target=0x202, result=0x44, rd written.
//  5 reset_n low during BUSY count=3 -> stall=0 and latch=0 immediately;
//    a following ADD completes normally with no stale MUL output.
//  6 SRA 0x80000000 >> 4 -> 0xF8000000; SRL -> 0x08000000; SLTU 0xFFFFFFFF<1 -> 0, SLT -> 1.

Source files
------------

// File: rtl/agex_stage.sv
// agex_stage: execute / address-generation stage sitting directly after decode.
//   Computes ALU results, load/store addresses and branch/jump outcomes, redirects
//   fetch on a taken control transfer, and runs MUL on an iterative shift-add
//   multiplier that stalls decode while it works.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   de_*                          decode latch fields (valid, op, pc, pcplus, operands, imm, wr_reg, rd, tag)
//   br_mispred_AGEX/br_target_AGEX  combinational fetch redirect and its target PC
//   mul_stall_AGEX                combinational decode stall while the multiplier is busy
//   agex_*                        registered AGEX latch towards the memory stage

package agex_pkg;
  localparam int IOPBITS = 6;
  typedef enum logic [IOPBITS-1:0] {
    ADD_I, ADDI_I, SUB_I, AND_I, ANDI_I, OR_I, ORI_I, XOR_I, XORI_I,
    SLT_I, SLTI_I, SLTU_I, SLTIU_I, SLL_I, SLLI_I, SRL_I, SRLI_I, SRA_I, SRAI_I,
    LUI_I, AUIPC_I, LW_I, SW_I,
    BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I,
    JAL_I, JALR_I, MUL_I, CSRR_I, CSRW_I, INVALID_I
  } op_e;
endpackage

// Protocol checker: decode must only present bubbles while the multiplier is busy,
// and a redirect can never coincide with a stall.
module agex_stage_chk (
  input logic clk,
  input logic reset_n,
  input logic busy_i,
  input logic de_valid_i,
  input logic mispred_i,
  input logic stall_i
);
  a_no_valid_in_busy: assert property (@(posedge clk) disable iff (!reset_n) busy_i |-> !de_valid_i);
  a_no_mispred_and_stall: assert property (@(posedge clk) disable iff (!reset_n) !(mispred_i && stall_i));
endmodule

module agex_stage
  import agex_pkg::*;
#(
  parameter int DBITS    = 32,
  parameter int MUL_STEP = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               de_valid,
  input  logic [IOPBITS-1:0] de_op,
  input  logic [DBITS-1:0]   de_pc,
  input  logic [DBITS-1:0]   de_pcplus,
  input  logic [DBITS-1:0]   de_rs1_val,
  input  logic [DBITS-1:0]   de_rs2_val,
  input  logic [DBITS-1:0]   de_imm,
  input  logic               de_wr_reg,
  input  logic [4:0]         de_rd,
  input  logic [DBITS-1:0]   de_inst_count,
  output logic               br_mispred_AGEX,
  output logic [DBITS-1:0]   br_target_AGEX,
  output logic               mul_stall_AGEX,
  output logic               agex_valid,
  output logic [IOPBITS-1:0] agex_op,
  output logic [DBITS-1:0]   agex_pc,
  output logic [DBITS-1:0]   agex_result,
  output logic [DBITS-1:0]   agex_st_data,
  output logic               agex_wr_reg,
  output logic [4:0]         agex_rd,
  output logic [DBITS-1:0]   agex_inst_count
);

  localparam int N_MUL = DBITS / MUL_STEP;
  localparam int CW    = (N_MUL > 1) ? $clog2(N_MUL) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N_MUL - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  typedef struct packed {
    logic               valid;
    logic [IOPBITS-1:0] op;
    logic [DBITS-1:0]   pc;
    logic [DBITS-1:0]   result;
    logic [DBITS-1:0]   st_data;
    logic               wr_reg;
    logic [4:0]         rd;
    logic [DBITS-1:0]   inst_count;
  } latch_t;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DBITS-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  latch_t           cap_q, cap_d, lat_q, lat_d;

  op_e              op_s;
  logic [DBITS-1:0] alu_s, tgt_s, prod_s, sum_s;
  logic             taken_s, wr_s, is_mul_s;

  assign op_s     = op_e'(de_op);
  assign is_mul_s = de_valid && (op_s == MUL_I);

  // Single-cycle ALU, address generation and control-transfer resolution.
  always_comb begin
    alu_s   = '0;
    tgt_s   = de_pc + de_imm;
    taken_s = 1'b0;
    wr_s    = de_wr_reg;
    case (op_s)
      ADD_I:    alu_s = de_rs1_val + de_rs2_val;
      ADDI_I:   alu_s = de_rs1_val + de_imm;
      SUB_I:    alu_s = de_rs1_val - de_rs2_val;
      AND_I:    alu_s = de_rs1_val & de_rs2_val;
      ANDI_I:   alu_s = de_rs1_val & de_imm;
      OR_I:     alu_s = de_rs1_val | de_rs2_val;
      ORI_I:    alu_s = de_rs1_val | de_imm;
      XOR_I:    alu_s = de_rs1_val ^ de_rs2_val;
      XORI_I:   alu_s = de_rs1_val ^ de_imm;
      SLT_I:    alu_s = {{(DBITS-1){1'b0}}, $signed(de_rs1_val) < $signed(de_rs2_val)};
      SLTI_I:   alu_s = {{(DBITS-1){1'b0}}, $signed(de_rs1_val) < $signed(de_imm)};
      SLTU_I:   alu_s = {{(DBITS-1){1'b0}}, de_rs1_val < de_rs2_val};
      SLTIU_I:  alu_s = {{(DBITS-1){1'b0}}, de_rs1_val < de_imm};
      SLL_I:    alu_s = de_rs1_val << de_rs2_val[4:0];
      SLLI_I:   alu_s = de_rs1_val << de_imm[4:0];
      SRL_I:    alu_s = de_rs1_val >> de_rs2_val[4:0];
      SRLI_I:   alu_s = de_rs1_val >> de_imm[4:0];
      SRA_I:    alu_s = DBITS'($signed(de_rs1_val) >>> de_rs2_val[4:0]);
      SRAI_I:   alu_s = DBITS'($signed(de_rs1_val) >>> de_imm[4:0]);
      LUI_I:    alu_s = de_imm;
      AUIPC_I:  alu_s = de_pc + de_imm;
      LW_I:     alu_s = de_rs1_val + de_imm;
      SW_I:     alu_s = de_rs1_val + de_imm;
      BEQ_I:    begin taken_s = (de_rs1_val == de_rs2_val); wr_s = 1'b0; end
      BNE_I:    begin taken_s = (de_rs1_val != de_rs2_val); wr_s = 1'b0; end
      BLT_I:    begin taken_s = ($signed(de_rs1_val) < $signed(de_rs2_val)); wr_s = 1'b0; end
      BGE_I:    begin taken_s = ($signed(de_rs1_val) >= $signed(de_rs2_val)); wr_s = 1'b0; end
      BLTU_I:   begin taken_s = (de_rs1_val < de_rs2_val); wr_s = 1'b0; end
      BGEU_I:   begin taken_s = (de_rs1_val >= de_rs2_val); wr_s = 1'b0; end
      JAL_I:    begin alu_s = de_pcplus; taken_s = 1'b1; end
      JALR_I:   begin
        alu_s   = de_pcplus;
        taken_s = 1'b1;
        tgt_s   = (de_rs1_val + de_imm) & {{(DBITS-1){1'b1}}, 1'b0};
      end
      CSRW_I:   alu_s = de_rs1_val;
      CSRR_I:   alu_s = '0;
      MUL_I:    alu_s = '0;
      INVALID_I: wr_s = 1'b0;
      default:  wr_s = 1'b0;
    endcase
  end

  // One shift-add step: multiplicand times the low MUL_STEP multiplier bits.
  assign prod_s = mcand_q * {{(DBITS-MUL_STEP){1'b0}}, mplier_q[MUL_STEP-1:0]};
  assign sum_s  = acc_q + prod_s;

  // Redirect only from IDLE; a branch is never consumed while the multiplier runs.
  assign br_mispred_AGEX = de_valid && (state_q == S_IDLE) && taken_s;
  assign br_target_AGEX  = tgt_s;
  // Stall covers the accept cycle and every busy cycle except the last one.
  assign mul_stall_AGEX  = (state_q == S_IDLE) ? is_mul_s : (count_q < LAST_CNT);

  // Multiplier FSM next state and AGEX latch next value.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cap_d    = cap_q;
    lat_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (is_mul_s) begin
          cap_d    = '{valid: 1'b1, op: de_op, pc: de_pc, result: '0, st_data: de_rs2_val,
                       wr_reg: de_wr_reg, rd: de_rd, inst_count: de_inst_count};
          acc_d    = '0;
          count_d  = '0;
          mcand_d  = de_rs1_val;
          mplier_d = de_rs2_val;
          state_d  = S_BUSY;
        end else if (de_valid) begin
          lat_d = '{valid: 1'b1, op: de_op, pc: de_pc, result: alu_s, st_data: de_rs2_val,
                    wr_reg: wr_s, rd: de_rd, inst_count: de_inst_count};
        end else begin
          lat_d = '0;
        end
      end
      S_BUSY: begin
        acc_d    = sum_s;
        mcand_d  = mcand_q << MUL_STEP;
        mplier_d = mplier_q >> MUL_STEP;
        count_d  = count_q + CW'(1);
        if (count_q == LAST_CNT) begin
          lat_d        = cap_q;
          lat_d.result = sum_s;
          count_d      = '0;
          state_d      = S_IDLE;
        end else begin
          lat_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, multiplier datapath and AGEX latch registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cap_q    <= '0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cap_q    <= cap_d;
      lat_q    <= lat_d;
    end
  end

  assign agex_valid      = lat_q.valid;
  assign agex_op         = lat_q.op;
  assign agex_pc         = lat_q.pc;
  assign agex_result     = lat_q.result;
  assign agex_st_data    = lat_q.st_data;
  assign agex_wr_reg     = lat_q.wr_reg;
  assign agex_rd         = lat_q.rd;
  assign agex_inst_count = lat_q.inst_count;

  agex_stage_chk u_chk (
    .clk        (clk),
    .reset_n    (reset_n),
    .busy_i     (state_q == S_BUSY),
    .de_valid_i (de_valid),
    .mispred_i  (br_mispred_AGEX),
    .stall_i    (mul_stall_AGEX)
  );

endmodule

// File: tb/tb_agex_stage.sv
// tb_agex_stage: directed self-checking bench for agex_stage.
module tb_agex_stage;
  import agex_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        de_valid;
  logic [5:0]  de_op;
  logic [31:0] de_pc, de_pcplus, de_rs1_val, de_rs2_val, de_imm, de_inst_count;
  logic        de_wr_reg;
  logic [4:0]  de_rd;
  logic        br_mispred_AGEX, mul_stall_AGEX;
  logic [31:0] br_target_AGEX;
  logic        agex_valid, agex_wr_reg;
  logic [5:0]  agex_op;
  logic [31:0] agex_pc, agex_result, agex_st_data, agex_inst_count;
  logic [4:0]  agex_rd;

  int total = 0;
  int bad = 0;
  logic [31:0] tag = 32'd100;

  always #5 clk = ~clk;

  agex_stage #(.DBITS(32), .MUL_STEP(4)) dut (
    .clk(clk), .reset_n(reset_n), .de_valid(de_valid), .de_op(de_op),
    .de_pc(de_pc), .de_pcplus(de_pcplus), .de_rs1_val(de_rs1_val), .de_rs2_val(de_rs2_val),
    .de_imm(de_imm), .de_wr_reg(de_wr_reg), .de_rd(de_rd), .de_inst_count(de_inst_count),
    .br_mispred_AGEX(br_mispred_AGEX), .br_target_AGEX(br_target_AGEX),
    .mul_stall_AGEX(mul_stall_AGEX), .agex_valid(agex_valid), .agex_op(agex_op),
    .agex_pc(agex_pc), .agex_result(agex_result), .agex_st_data(agex_st_data),
    .agex_wr_reg(agex_wr_reg), .agex_rd(agex_rd), .agex_inst_count(agex_inst_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    de_valid = 1'b0; de_op = ADD_I; de_pc = '0; de_pcplus = '0;
    de_rs1_val = '0; de_rs2_val = '0; de_imm = '0; de_wr_reg = 1'b0; de_rd = '0; de_inst_count = '0;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] pcplus);
    de_valid = 1'b1; de_op = op; de_rs1_val = rs1; de_rs2_val = rs2; de_imm = imm;
    de_pc = pc; de_pcplus = pcplus; de_wr_reg = 1'b1; de_rd = 5'd7;
    de_inst_count = tag; tag = tag + 32'd1;
  endtask

  task automatic test_reset();
    bubble();
    reset_n = 1'b0;
    #12;
    total++; if (agex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", agex_valid); end
    total++; if (agex_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", agex_result); end
    total++; if ({agex_wr_reg, agex_rd, agex_inst_count} !== 38'h0) begin bad++; $display("FAIL reset_fields got=%h exp=0", {agex_wr_reg, agex_rd, agex_inst_count}); end
    total++; if ({br_mispred_AGEX, mul_stall_AGEX} !== 2'b00) begin bad++; $display("FAIL reset_ctl got=%b exp=00", {br_mispred_AGEX, mul_stall_AGEX}); end
    @(negedge clk); reset_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    logic [31:0] t;
    t = tag;
    drive(ADD_I, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h40, 32'h44);
    #1;
    total++; if (br_mispred_AGEX !== 1'b0) begin bad++; $display("FAIL add_mispred got=%b exp=0", br_mispred_AGEX); end
    step();
    total++; if (agex_result !== 32'h8000_0000) begin bad++; $display("FAIL add_result got=%h exp=80000000", agex_result); end
    total++; if ({agex_valid, agex_wr_reg, agex_rd} !== {1'b1, 1'b1, 5'd7}) begin bad++; $display("FAIL add_flags got=%b exp=1100111", {agex_valid, agex_wr_reg, agex_rd}); end
    total++; if (agex_inst_count !== t) begin bad++; $display("FAIL add_tag got=%h exp=%h", agex_inst_count, t); end
    drive(SUB_I, 32'h0, 32'h1, 32'h0, 32'h48, 32'h4C);
    step();
    total++; if (agex_result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sub_wrap got=%h exp=ffffffff", agex_result); end
    bubble();
    step();
    total++; if ({agex_valid, agex_wr_reg} !== 2'b00) begin bad++; $display("FAIL bubble_latch got=%b exp=00", {agex_valid, agex_wr_reg}); end
  endtask

  task automatic test_branch();
    drive(BEQ_I, 32'd5, 32'd5, 32'h20, 32'h100, 32'h104);
    #1;
    total++; if (br_mispred_AGEX !== 1'b1) begin bad++; $display("FAIL beq_taken got=%b exp=1", br_mispred_AGEX); end
    total++; if (br_target_AGEX !== 32'h120) begin bad++; $display("FAIL beq_target got=%h exp=120", br_target_AGEX); end
    step();
    total++; if ({agex_valid, agex_wr_reg} !== 2'b10) begin bad++; $display("FAIL beq_latch got=%b exp=10", {agex_valid, agex_wr_reg}); end
    drive(BEQ_I, 32'd5, 32'd6, 32'h20, 32'h100, 32'h104);
    #1;
    total++; if (br_mispred_AGEX !== 1'b0) begin bad++; $display("FAIL beq_not_taken got=%b exp=0", br_mispred_AGEX); end
    step();
    drive(BEQ_I, 32'd5, 32'd5, 32'h20, 32'h100, 32'h104);
    de_valid = 1'b0;
    #1;
    total++; if (br_mispred_AGEX !== 1'b0) begin bad++; $display("FAIL beq_bubble got=%b exp=0", br_mispred_AGEX); end
    step();
    drive(JAL_I, 32'h0, 32'h0, 32'hFFFF_FFF8, 32'h200, 32'h204);
    #1;
    total++; if ({br_mispred_AGEX, br_target_AGEX} !== {1'b1, 32'h1F8}) begin bad++; $display("FAIL jal_redirect got=%h exp=1000001f8", {br_mispred_AGEX, br_target_AGEX}); end
    step();
    total++; if (agex_result !== 32'h204) begin bad++; $display("FAIL jal_link got=%h exp=204", agex_result); end
  endtask

  task automatic test_jalr();
    drive(JALR_I, 32'h203, 32'h0, 32'h0, 32'h40, 32'h44);
    #1;
    total++; if ({br_mispred_AGEX, br_target_AGEX} !== {1'b1, 32'h202}) begin bad++; $display("FAIL jalr_target got=%h exp=100000202", {br_mispred_AGEX, br_target_AGEX}); end
    step();
    total++; if (agex_result !== 32'h44) begin bad++; $display("FAIL jalr_link got=%h exp=44", agex_result); end
    total++; if ({agex_wr_reg, agex_rd} !== {1'b1, 5'd7}) begin bad++; $display("FAIL jalr_rd got=%b exp=100111", {agex_wr_reg, agex_rd}); end
  endtask

  task automatic test_alu_misc();
    logic [5:0]  ops [9] = '{SRA_I, SRL_I, SLTU_I, SLT_I, LUI_I, AUIPC_I, LW_I, SW_I, INVALID_I};
    logic [31:0] r1s [9] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h100, 32'h200, 32'h1};
    logic [31:0] r2s [9] = '{32'h4, 32'h4, 32'h1, 32'h1, 32'h0, 32'h0, 32'hAA, 32'hDEAD, 32'h1};
    logic [31:0] ims [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_5000, 32'h2000, 32'hFFFF_FFFC, 32'h8, 32'h0};
    logic [31:0] exp [9] = '{32'hF800_0000, 32'h0800_0000, 32'h0, 32'h1, 32'h1234_5000, 32'h3000, 32'hFC, 32'h208, 32'h0};
    for (int i = 0; i < 9; i++) begin
      drive(ops[i], r1s[i], r2s[i], ims[i], 32'h1000, 32'h1004);
      #1;
      if (ops[i] == INVALID_I) begin
        total++; if (br_mispred_AGEX !== 1'b0) begin bad++; $display("FAIL invalid_mispred got=%b exp=0", br_mispred_AGEX); end
      end
      step();
      if (ops[i] == INVALID_I) begin
        total++; if ({agex_valid, agex_wr_reg} !== 2'b10) begin bad++; $display("FAIL invalid_latch got=%b exp=10", {agex_valid, agex_wr_reg}); end
      end else begin
        total++; if (agex_result !== exp[i]) begin bad++; $display("FAIL alu_row%0d got=%h exp=%h", i, agex_result, exp[i]); end
      end
      if (ops[i] == LW_I || ops[i] == SW_I) begin
        total++; if (agex_st_data !== r2s[i]) begin bad++; $display("FAIL st_data_row%0d got=%h exp=%h", i, agex_st_data, r2s[i]); end
      end
    end
    bubble();
    step();
  endtask

  task automatic test_mul();
    logic [31:0] as [2] = '{32'd7, 32'hFFFF_FFFF};
    logic [31:0] bs [2] = '{32'd6, 32'd2};
    logic [31:0] ex [2] = '{32'd42, 32'hFFFF_FFFE};
    for (int v = 0; v < 2; v++) begin
      int stalls = 0;
      int res_edge = 0;
      int mp = 0;
      logic [31:0] res = '0;
      logic [31:0] t;
      logic [4:0]  rd = '0;
      logic [31:0] cnt = '0;
      t = tag;
      drive(MUL_I, as[v], bs[v], 32'h0, 32'h300, 32'h304);
      de_rd = 5'd9;
      #1;
      for (int e = 1; e <= 12; e++) begin
        if (mul_stall_AGEX) stalls++;
        if (br_mispred_AGEX) mp++;
        step();
        if (e == 1) bubble();
        if (agex_valid && res_edge == 0) begin
          res_edge = e; res = agex_result; rd = agex_rd; cnt = agex_inst_count;
        end
      end
      total++; if (stalls != 8) begin bad++; $display("FAIL mul%0d_stall_cycles got=%0d exp=8", v, stalls); end
      total++; if (res_edge != 9) begin bad++; $display("FAIL mul%0d_latency got=%0d exp=9", v, res_edge); end
      total++; if (res !== ex[v]) begin bad++; $display("FAIL mul%0d_result got=%h exp=%h", v, res, ex[v]); end
      total++; if ({rd, cnt} !== {5'd9, t}) begin bad++; $display("FAIL mul%0d_fields got=%h exp=%h", v, {rd, cnt}, {5'd9, t}); end
      total++; if (mp != 0) begin bad++; $display("FAIL mul%0d_mispred got=%0d exp=0", v, mp); end
    end
  endtask

  task automatic test_reset_mid_mul();
    int stale = 0;
    drive(MUL_I, 32'd3, 32'd5, 32'h0, 32'h400, 32'h404);
    #1;
    step();
    bubble();
    step(); step(); step();
    total++; if (mul_stall_AGEX !== 1'b1) begin bad++; $display("FAIL midmul_busy got=%b exp=1", mul_stall_AGEX); end
    #2 reset_n = 1'b0;
    #1;
    total++; if ({mul_stall_AGEX, agex_valid, agex_result} !== 34'h0) begin bad++; $display("FAIL midmul_reset got=%h exp=0", {mul_stall_AGEX, agex_valid, agex_result}); end
    @(negedge clk); reset_n = 1'b1;
    step();
    drive(ADD_I, 32'd2, 32'd3, 32'h0, 32'h500, 32'h504);
    #1;
    step();
    total++; if ({agex_valid, agex_result} !== {1'b1, 32'd5}) begin bad++; $display("FAIL post_reset_add got=%h exp=100000005", {agex_valid, agex_result}); end
    bubble();
    for (int e = 0; e < 12; e++) begin
      step();
      if (agex_valid) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL stale_mul_output got=%0d exp=0", stale); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_jalr();
    test_alu_misc();
    test_mul();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
